// File: rtl/timer_irq_pkg.sv
// Shared constants and address decode for the memory-mapped reload timer.
// Used by the timer itself and by the peripheral-bus decoder / software memory map.
package timer_irq_pkg;

  localparam logic [31:0] TIMER_BASE     = 32'h4000_0000;
  localparam logic [31:0] TIMER_TH_OFS   = 32'd0;
  localparam logic [31:0] TIMER_TL_OFS   = 32'd4;
  localparam logic [31:0] TIMER_TCON_OFS = 32'd8;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_TH,
    SEL_TL,
    SEL_TCON
  } reg_sel_e;

  // Word-granular compare: byte-lane bits of the address never take part.
  function automatic reg_sel_e decode_sel(input logic [29:0] word_addr,
                                          input logic [29:0] base_word);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (word_addr == base_word + TIMER_TH_OFS[31:2])        sel = SEL_TH;
    else if (word_addr == base_word + TIMER_TL_OFS[31:2])   sel = SEL_TL;
    else if (word_addr == base_word + TIMER_TCON_OFS[31:2]) sel = SEL_TCON;
    return sel;
  endfunction

endpackage

// File: rtl/timer_irq_if.sv
// MEM-stage peripheral bus as seen by the timer: read/write strobes, address, data.
// Master is the MEM stage, slave is the timer; ReadData is combinational from the slave.
interface timer_irq_if;

  logic        MemRd;
  logic        MemWr;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemRd, MemWr, Addr, WriteData,
    input  ReadData
  );

  modport slave (
    input  MemRd, MemWr, Addr, WriteData,
    output ReadData
  );

endinterface

// File: rtl/timer_irq.sv
// 32-bit reload timer (TH/TL/TCON) with level IRQ = IE & ST; reads combinational, writes next edge.
// No backpressure: every bus access completes in the cycle it is presented.
module timer_irq
  import timer_irq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TIMER_BASE
) (
  input  logic         clk,
  input  logic         reset,
  timer_irq_if.slave   bus,
  output logic         IRQ
);

  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic        r_en;
  logic        r_ie;
  logic        r_st;

  reg_sel_e    w_sel;
  logic        w_wr_th;
  logic        w_wr_tl;
  logic        w_wr_tcon;
  logic        w_ovf;
  logic        w_ovf_set;
  logic [2:0]  w_tcon;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  assign w_sel         = decode_sel(bus.Addr[31:2], BASE_WORD);
  assign w_unused_addr = ^bus.Addr[1:0];

  assign w_wr_th   = bus.MemWr && (w_sel == SEL_TH);
  assign w_wr_tl   = bus.MemWr && (w_sel == SEL_TL);
  assign w_wr_tcon = bus.MemWr && (w_sel == SEL_TCON);

  assign w_ovf     = r_en && (r_tl == 32'hFFFF_FFFF);
  assign w_ovf_set = w_ovf && r_ie;

  always_comb begin
    w_tcon          = '0;
    w_tcon[TCON_EN] = r_en;
    w_tcon[TCON_IE] = r_ie;
    w_tcon[TCON_ST] = r_st;
  end

  always_comb begin
    w_rdata = '0;
    if (bus.MemRd) begin
      case (w_sel)
        SEL_TH:   w_rdata = r_th;
        SEL_TL:   w_rdata = r_tl;
        SEL_TCON: w_rdata = {29'b0, w_tcon};
        default:  w_rdata = '0;
      endcase
    end
  end

  assign bus.ReadData = w_rdata;
  assign IRQ          = r_ie & r_st;

  // Software writes beat the counter; a reload always uses the TH value from before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th <= '0;
      r_tl <= '0;
      r_en <= 1'b0;
      r_ie <= 1'b0;
      r_st <= 1'b0;
    end else begin
      if (w_wr_th) r_th <= bus.WriteData;

      if (w_wr_tl)    r_tl <= bus.WriteData;
      else if (r_en)  r_tl <= w_ovf ? r_th : r_tl + 32'd1;

      // Hardware overflow set is OR-ed into a TCON write so no interrupt is lost.
      if (w_wr_tcon) begin
        r_en <= bus.WriteData[TCON_EN];
        r_ie <= bus.WriteData[TCON_IE];
        r_st <= bus.WriteData[TCON_ST] | w_ovf_set;
      end else if (w_ovf_set) begin
        r_st <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: reset, reload/IRQ, clear, collisions, decode, software IRQ.
module tb_timer_irq;

  localparam logic [31:0] TH_A   = 32'h4000_0000;
  localparam logic [31:0] TL_A   = 32'h4000_0004;
  localparam logic [31:0] TCON_A = 32'h4000_0008;
  localparam logic [31:0] MISS_A = 32'h4000_000C;

  logic clk;
  logic reset;
  logic irq;
  int   tests_run;
  int   tests_failed;

  timer_irq_if bus ();

  timer_irq #(.BASE_ADDR(32'h4000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .IRQ   (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.MemWr     = 1'b1;
    bus.Addr      = a;
    bus.WriteData = d;
    @(posedge clk);
    #1;
    bus.MemWr     = 1'b0;
    bus.WriteData = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.MemRd = 1'b1;
    bus.Addr  = a;
    #1;
    d         = bus.ReadData;
    bus.MemRd = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    bus_write(TL_A, 32'd5);
    bus_write(TCON_A, 32'd7);
    tick();
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL reset_pre_irq: got %b expected 1", irq); end
    #4;
    reset = 1'b0;
    #1;
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_async_irq: got %b expected 0", irq); end
    tests_run++;
    if (bus.ReadData !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 0", bus.ReadData); end
    bus_read(TL_A, rd);
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_tl_during: got %h expected 0", rd); end
    tick();
    reset = 1'b1;
    tick();
    bus_read(TL_A, rd);
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_tl_after: got %h expected 0", rd); end
    bus_read(TH_A, rd);
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_th_after: got %h expected 0", rd); end
    bus_read(TCON_A, rd);
    tests_run++;
    if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_tcon_after: got %h expected 0", rd); end
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq_after: got %b expected 0", irq); end
  endtask

  task automatic test_reload();
    logic [31:0] rd;
    logic [31:0] exp_tl [4];
    logic        exp_irq [4];
    exp_tl  = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    exp_irq = '{1'b0, 1'b0, 1'b0, 1'b1};
    bus_write(TH_A, 32'hFFFF_FFFC);
    bus_write(TL_A, 32'hFFFF_FFFC);
    bus_write(TCON_A, 32'd3);
    bus_read(TL_A, rd);
    tests_run++;
    if (rd !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL reload_tl_start: got %h expected fffffffc", rd); end
    for (int k = 0; k < 4; k++) begin
      tick();
      bus_read(TL_A, rd);
      tests_run++;
      if (rd !== exp_tl[k]) begin tests_failed++; $display("FAIL reload_tl_%0d: got %h expected %h", k, rd, exp_tl[k]); end
      tests_run++;
      if (irq !== exp_irq[k]) begin tests_failed++; $display("FAIL reload_irq_%0d: got %b expected %b", k, irq, exp_irq[k]); end
    end
  endtask

  task automatic test_clear_retrigger();
    logic [31:0] rd;
    logic [31:0] exp_tl [3];
    logic        exp_irq [3];
    exp_tl  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    exp_irq = '{1'b0, 1'b0, 1'b1};
    bus_write(TCON_A, 32'd3);
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL clear_irq: got %b expected 0", irq); end
    bus_read(TL_A, rd);
    tests_run++;
    if (rd !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL clear_tl: got %h expected fffffffd", rd); end
    for (int k = 0; k < 3; k++) begin
      tick();
      bus_read(TL_A, rd);
      tests_run++;
      if (rd !== exp_tl[k]) begin tests_failed++; $display("FAIL retrig_tl_%0d: got %h expected %h", k, rd, exp_tl[k]); end
      tests_run++;
      if (irq !== exp_irq[k]) begin tests_failed++; $display("FAIL retrig_irq_%0d: got %b expected %b", k, irq, exp_irq[k]); end
    end
  endtask

  task automatic test_collision_tcon();
    logic [31:0] rd;
    repeat (3) tick();
    bus_read(TL_A, rd);
    tests_run++;
    if (rd !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL coll_tcon_setup: got %h expected ffffffff", rd); end
    bus_write(TCON_A, 32'd3);
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL coll_tcon_irq: got %b expected 1", irq); end
    bus_read(TCON_A, rd);
    tests_run++;
    if (rd !== 32'd7) begin tests_failed++; $display("FAIL coll_tcon_st: got %h expected 7", rd); end
    bus_read(TL_A, rd);
    tests_run++;
    if (rd !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL coll_tcon_tl: got %h expected fffffffc", rd); end
  endtask

  task automatic test_collision_tl();
    logic [31:0] rd;
    bus_write(TL_A, 32'h0000_0010);
    bus_read(TL_A, rd);
    tests_run++;
    if (rd !== 32'h0000_0010) begin tests_failed++; $display("FAIL coll_tl_write: got %h expected 00000010", rd); end
    tick();
    bus_read(TL_A, rd);
    tests_run++;
    if (rd !== 32'h0000_0011) begin tests_failed++; $display("FAIL coll_tl_next: got %h expected 00000011", rd); end
  endtask

  task automatic test_decode();
    logic [31:0] rd;
    bus_write(TCON_A, 32'd3);
    bus_read(TCON_A, rd);
    tests_run++;
    if (rd !== 32'd3) begin tests_failed++; $display("FAIL dec_tcon: got %h expected 3", rd); end
    bus_read(TCON_A + 32'd1, rd);
    tests_run++;
    if (rd !== 32'd3) begin tests_failed++; $display("FAIL dec_lowbits: got %h expected 3", rd); end
    bus_read(MISS_A, rd);
    tests_run++;
    if (rd !== 32'd0) begin tests_failed++; $display("FAIL dec_miss_rd: got %h expected 0", rd); end
    bus.MemRd = 1'b0;
    bus.Addr  = TH_A;
    #1;
    tests_run++;
    if (bus.ReadData !== 32'd0) begin tests_failed++; $display("FAIL dec_no_rd: got %h expected 0", bus.ReadData); end
    bus_write(MISS_A, 32'hFFFF_FFFF);
    bus_read(TH_A, rd);
    tests_run++;
    if (rd !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL dec_miss_wr_th: got %h expected fffffffc", rd); end
    bus_read(TCON_A, rd);
    tests_run++;
    if (rd !== 32'd3) begin tests_failed++; $display("FAIL dec_miss_wr_tcon: got %h expected 3", rd); end
  endtask

  task automatic test_sw_irq();
    logic [31:0] rd;
    bus_write(TCON_A, 32'hFFFF_FFF6);
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL swirq_irq: got %b expected 1", irq); end
    bus_read(TCON_A, rd);
    tests_run++;
    if (rd !== 32'd6) begin tests_failed++; $display("FAIL swirq_tcon: got %h expected 6", rd); end
    bus_write(TL_A, 32'h0000_1234);
    repeat (3) tick();
    bus_read(TL_A, rd);
    tests_run++;
    if (rd !== 32'h0000_1234) begin tests_failed++; $display("FAIL swirq_tl_frozen: got %h expected 00001234", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    bus_write(TH_A, 32'hFFFF_FFFF);
    bus_write(TL_A, 32'hFFFF_FFFF);
    bus_write(TCON_A, 32'd3);
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL b2b_irq_start: got %b expected 0", irq); end
    tick();
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL b2b_irq_ovf: got %b expected 1", irq); end
    bus_write(TCON_A, 32'd3);
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL b2b_irq_hold: got %b expected 1", irq); end
    bus_read(TL_A, rd);
    tests_run++;
    if (rd !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL b2b_tl: got %h expected ffffffff", rd); end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b0;
    bus.MemRd     = 1'b0;
    bus.MemWr     = 1'b0;
    bus.Addr      = '0;
    bus.WriteData = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    test_reset();
    test_reload();
    test_clear_retrigger();
    test_collision_tcon();
    test_collision_tl();
    test_decode();
    test_sw_irq();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
